// File: rtl/alu_share_ctrl_if.sv
// Bundle of every signal between alu_share_ctrl and its neighbours: two
// requester ports (request + response) and the shared ALU's operand/result
// lines. The slave modport is the controller's view; the master modport is the
// view of the surrounding requesters and ALU.
interface alu_share_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             resp0_valid;
    logic             resp0_ready;
    logic [WIDTH-1:0] resp0_result;
    logic             resp0_zero;

    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp1_result;
    logic             resp1_zero;

    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_data1;
    logic [WIDTH-1:0] alu_data2;
    logic [WIDTH-1:0] alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_result, resp0_zero,
        output resp1_valid, resp1_result, resp1_zero,
        input  resp0_ready, resp1_ready,
        output alu_op, alu_data1, alu_data2,
        input  alu_result
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_result, resp0_zero,
        input  resp1_valid, resp1_result, resp1_zero,
        output resp0_ready, resp1_ready,
        input  alu_op, alu_data1, alu_data2,
        output alu_result
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one registered-output ALU between two requesters. A round-robin
// arbiter picks a request in IDLE, the operands are held on the ALU for one
// cycle, the ALU result is captured a cycle later and then presented on the
// owner's response port until it is taken. Only one operation is in flight.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no operation in flight; arbiter may accept a request
//   ISSUE   | alu_* held stable; the ALU samples them at the end of cycle
//   CAPTURE | alu_result valid; latched into result register with zero flag
//   RESP    | resp<owner>_valid high until resp<owner>_ready handshake
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input logic             clk,
    input logic             rst,
    alu_share_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;

    // last = requester granted most recently; the other one wins a tie.
    logic             last;
    logic             owner;

    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] data1_q;
    logic [WIDTH-1:0] data2_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic             grant0;
    logic             grant1;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic             accept_id;
    logic             resp_take;

    // Round-robin winner from the two valids and the last-granted pointer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last;
            grant1 = ~last;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
    end

    // Next-state and handshake decode; ready is offered only in IDLE and never while rst is high.
    always_comb begin
        state_nx  = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        accept    = 1'b0;
        accept_id = 1'b0;
        resp_take = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    ready0 = grant0;
                    ready1 = grant1;
                    if (grant0 || grant1) begin
                        accept    = 1'b1;
                        accept_id = grant1;
                        state_nx  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_nx = CAPTURE;
            end
            CAPTURE: begin
                state_nx = RESP;
            end
            RESP: begin
                resp_take = owner ? bus.resp1_ready : bus.resp0_ready;
                if (resp_take) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Arbitration pointer, owner and the operand registers feeding the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= 1'b1;
            owner   <= 1'b0;
            op_q    <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else if (accept) begin
            last  <= accept_id;
            owner <= accept_id;
            if (accept_id) begin
                op_q    <= bus.req1_op;
                data1_q <= bus.req1_a;
                data2_q <= bus.req1_b;
            end else begin
                op_q    <= bus.req0_op;
                data1_q <= bus.req0_a;
                data2_q <= bus.req0_b;
            end
        end
    end

    // Result capture; the ALU output is only trusted in CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (state == CAPTURE) begin
            result_q <= bus.alu_result;
            zero_q   <= (bus.alu_result == '0);
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;

    assign bus.alu_op       = op_q;
    assign bus.alu_data1    = data1_q;
    assign bus.alu_data2    = data2_q;

    // Both response ports share one result register; valid selects the reader.
    assign bus.resp0_valid  = (state == RESP) && !owner;
    assign bus.resp1_valid  = (state == RESP) &&  owner;
    assign bus.resp0_result = result_q;
    assign bus.resp1_result = result_q;
    assign bus.resp0_zero   = zero_q;
    assign bus.resp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a registered behavioural ALU, queue-driven
// requesters, and a transaction-level monitor that predicts grants, latency
// and results from the arbitration and timing rules.
module tb_alu_share_ctrl;
    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct packed {
        logic        port;
        logic [31:0] result;
        logic        zero;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return ~a;
            3'd3:    return a << b[4:0];
            3'd4:    return a >> b[4:0];
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Behavioural ALU with one cycle of registered latency.
    logic [31:0] alu_res_q;
    always @(posedge clk) alu_res_q <= alu_fn(bus.alu_op, bus.alu_data1, bus.alu_data2);
    assign bus.alu_result = alu_res_q;

    // Requester side
    req_t q0[$];
    req_t q1[$];
    bit   took0 = 0;
    bit   took1 = 0;
    int   hold0 = 0;
    int   hold1 = 0;
    bit   rnd_ready = 0;

    initial begin
        bus.req0_valid = 0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
        forever begin
            @(posedge clk); #1;
            if (took0) begin void'(q0.pop_front()); took0 = 0; end
            if (took1) begin void'(q1.pop_front()); took1 = 0; end
            bus.req0_valid = (q0.size() != 0);
            if (q0.size() != 0) begin
                bus.req0_op = q0[0].op; bus.req0_a = q0[0].a; bus.req0_b = q0[0].b;
            end
            bus.req1_valid = (q1.size() != 0);
            if (q1.size() != 0) begin
                bus.req1_op = q1[0].op; bus.req1_a = q1[0].a; bus.req1_b = q1[0].b;
            end
            if (hold0 > 0) begin hold0--; bus.resp0_ready = 0; end
            else bus.resp0_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
            if (hold1 > 0) begin hold1--; bus.resp1_ready = 0; end
            else bus.resp1_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    // Reference model: one operation outstanding, response three cycles after accept.
    int    cyc = 0;
    bit    busy = 0;
    bit    last_m = 1;
    bit    after_rst = 0;
    bit    port_m = 0;
    int    acc_cyc = 0;
    int    hs_cyc = -100;
    int    stall0 = 0;
    req_t  cur_m;
    logic [31:0] res_m;
    int    grant_log[$];
    int    gap_log[$];
    resp_t resp_log[$];

    initial begin
        bit ev0, ev1, win, any;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check_val("rst_ready0", bus.req0_ready, 0);
                check_val("rst_ready1", bus.req1_ready, 0);
                busy = 0; last_m = 1; after_rst = 1;
            end else begin
                if (after_rst) begin
                    check_val("rst_alu_op", bus.alu_op, 0);
                    check_val("rst_alu_data1", bus.alu_data1, 0);
                    check_val("rst_alu_data2", bus.alu_data2, 0);
                    check_val("rst_result", bus.resp0_result, 0);
                    check_val("rst_zero", bus.resp0_zero, 0);
                    after_rst = 0;
                end
                if (busy) begin
                    ev0 = (cyc >= acc_cyc + 3) && !port_m;
                    ev1 = (cyc >= acc_cyc + 3) &&  port_m;
                    check_val("busy_ready0", bus.req0_ready, 0);
                    check_val("busy_ready1", bus.req1_ready, 0);
                    check_val("resp0_valid", bus.resp0_valid, ev0);
                    check_val("resp1_valid", bus.resp1_valid, ev1);
                    check_val("alu_op_hold", bus.alu_op, cur_m.op);
                    check_val("alu_data1_hold", bus.alu_data1, cur_m.a);
                    check_val("alu_data2_hold", bus.alu_data2, cur_m.b);
                    if (ev0) begin
                        check_val("resp0_result", bus.resp0_result, res_m);
                        check_val("resp0_zero", bus.resp0_zero, res_m == 0);
                        if (!bus.resp0_ready) stall0++;
                    end
                    if (ev1) begin
                        check_val("resp1_result", bus.resp1_result, res_m);
                        check_val("resp1_zero", bus.resp1_zero, res_m == 0);
                    end
                    if ((ev0 && bus.resp0_ready) || (ev1 && bus.resp1_ready)) begin
                        busy = 0;
                        hs_cyc = cyc;
                        resp_log.push_back('{port: port_m, result: res_m, zero: res_m == 0});
                    end
                end else begin
                    check_val("idle_resp0_valid", bus.resp0_valid, 0);
                    check_val("idle_resp1_valid", bus.resp1_valid, 0);
                    any = bus.req0_valid || bus.req1_valid;
                    if (bus.req0_valid && bus.req1_valid) win = ~last_m;
                    else win = bus.req1_valid;
                    check_val("grant_ready0", bus.req0_ready, any && !win);
                    check_val("grant_ready1", bus.req1_ready, any && win);
                    if (any) begin
                        busy = 1; acc_cyc = cyc; port_m = win; last_m = win;
                        if (win) begin
                            cur_m = '{op: bus.req1_op, a: bus.req1_a, b: bus.req1_b};
                            took1 = 1;
                        end else begin
                            cur_m = '{op: bus.req0_op, a: bus.req0_a, b: bus.req0_b};
                            took0 = 1;
                        end
                        res_m = alu_fn(cur_m.op, cur_m.a, cur_m.b);
                        grant_log.push_back(int'(win));
                        gap_log.push_back(cyc - hs_cyc);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy) && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        if (n >= budget) check_val("idle_timeout", 1, 0);
    endtask

    task automatic expect_resp(input string tag, input logic port, input logic [31:0] result, input logic zero);
        resp_t r;
        if (resp_log.size() == 0) begin
            check_val({tag, "_missing"}, 0, 1);
        end else begin
            r = resp_log.pop_front();
            check_val({tag, "_port"}, r.port, port);
            check_val({tag, "_result"}, r.result, result);
            check_val({tag, "_zero"}, r.zero, zero);
        end
    endtask

    task automatic expect_grant(input string tag, input int port);
        if (grant_log.size() == 0) check_val({tag, "_missing"}, 0, 1);
        else check_val(tag, grant_log.pop_front(), port);
    endtask

    task automatic at_drive();
        @(negedge clk); #2;
    endtask

    initial begin
        int n, gap;
        req_t r;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // single add on req0
        at_drive();
        q0.push_back('{op: 3'd0, a: 32'd5, b: 32'd7});
        wait_idle(50);
        expect_resp("add", 0, 32'd12, 0);

        // zero flag and set-less-than on req1
        at_drive();
        q1.push_back('{op: 3'd1, a: 32'd9, b: 32'd9});
        q1.push_back('{op: 3'd7, a: 32'd3, b: 32'd8});
        wait_idle(50);
        expect_resp("sub_zero", 1, 32'd0, 1);
        expect_resp("slt", 1, 32'd1, 0);

        // tie with both ports continuously valid
        grant_log.delete();
        at_drive();
        q0.push_back('{op: 3'd6, a: 32'h0000_00F0, b: 32'h0000_000F});
        q0.push_back('{op: 3'd6, a: 32'h1200_0000, b: 32'h0034_0000});
        q1.push_back('{op: 3'd6, a: 32'h0000_0A00, b: 32'h0000_0050});
        q1.push_back('{op: 3'd6, a: 32'h0000_0000, b: 32'h0000_0000});
        wait_idle(80);
        expect_grant("rr_g0", 0);
        expect_grant("rr_g1", 1);
        expect_grant("rr_g2", 0);
        expect_grant("rr_g3", 1);
        expect_resp("rr_r0", 0, 32'h0000_00FF, 0);
        expect_resp("rr_r1", 1, 32'h0000_0A50, 0);
        expect_resp("rr_r2", 0, 32'h1234_0000, 0);
        expect_resp("rr_r3", 1, 32'h0000_0000, 1);

        // backpressure on resp0 while req1 waits
        grant_log.delete();
        gap_log.delete();
        stall0 = 0;
        at_drive();
        hold0 = 14;
        q0.push_back('{op: 3'd0, a: 32'd100, b: 32'd23});
        n = 0;
        while (!busy && n < 20) begin at_drive(); n++; end
        q1.push_back('{op: 3'd5, a: 32'hFF00_FF00, b: 32'h0FF0_0FF0});
        wait_idle(80);
        check_val("bp_stall_cycles", (stall0 >= 10), 1);
        expect_grant("bp_g0", 0);
        expect_grant("bp_g1", 1);
        void'(gap_log.pop_front());
        if (gap_log.size() == 0) check_val("bp_gap_missing", 0, 1);
        else begin gap = gap_log.pop_front(); check_val("bp_accept_gap", gap, 1); end
        expect_resp("bp_r0", 0, 32'd123, 0);
        expect_resp("bp_r1", 1, 32'h0F00_0F00, 0);

        // reset during CAPTURE, then a tie must go to req0
        at_drive();
        q0.push_back('{op: 3'd0, a: 32'd1, b: 32'd2});
        n = 0;
        while (!busy && n < 20) begin at_drive(); n++; end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        repeat (6) at_drive();
        check_val("rst_drop_no_resp", resp_log.size(), 0);
        grant_log.delete();
        at_drive();
        q0.push_back('{op: 3'd0, a: 32'd40, b: 32'd2});
        q1.push_back('{op: 3'd1, a: 32'd40, b: 32'd2});
        wait_idle(60);
        expect_grant("rst_tie_g0", 0);
        expect_grant("rst_tie_g1", 1);
        expect_resp("rst_r0", 0, 32'd42, 0);
        expect_resp("rst_r1", 1, 32'd38, 0);

        // shift and not pass-through
        at_drive();
        q0.push_back('{op: 3'd3, a: 32'd1, b: 32'd4});
        q0.push_back('{op: 3'd2, a: 32'd0, b: 32'd0});
        wait_idle(50);
        expect_resp("shl", 0, 32'd16, 0);
        expect_resp("not", 0, 32'hFFFF_FFFF, 0);

        // randomized traffic with random response backpressure
        rnd_ready = 1;
        for (int i = 0; i < 600; i++) begin
            at_drive();
            if (q0.size() < 3 && $urandom_range(2) == 0) begin
                r.op = 3'($urandom_range(7));
                r.a = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
                r.b = ($urandom_range(3) == 0) ? r.a : $urandom;
                q0.push_back(r);
            end
            if (q1.size() < 3 && $urandom_range(2) == 0) begin
                r.op = 3'($urandom_range(7));
                r.a = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
                r.b = ($urandom_range(3) == 0) ? r.a : $urandom;
                q1.push_back(r);
            end
        end
        wait_idle(3000);
        rnd_ready = 0;
        repeat (3) at_drive();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares the single 32-bit ALU between two requesters, such as the instruction datapath and an address or branch unit. It round-robins between two valid/ready request ports and drives the ALU's opcode and operand inputs. It waits out the ALU's one-cycle registered latency, captures the result, and returns it with a zero flag on the winning requester's response port. Only one operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- OPW, 3, ALU opcode width: 000 add, 001 sub, 010 not, 011 shl, 100 shr, 101 and, 110 or, 111 set-less-than

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- reqN_valid  in  1  (N=0,1) request present
- reqN_ready  out  1  request accepted this cycle when high with reqN_valid
- reqN_op  in  OPW  opcode
- reqN_a, reqN_b  in  WIDTH  operands
- respN_valid  out  1  result available for requester N
- respN_ready  in  1  requester N takes result
- respN_result  out  WIDTH  result
- respN_zero  out  1  result == 0
- alu_op  out  OPW  to ALU ALUOp
- alu_data1, alu_data2  out  WIDTH  to ALU operands
- alu_result  in  WIDTH  from ALU ALUResult (registered inside ALU on posedge clk)

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: the arbiter picks a winner among the valid requests. It asserts reqW_ready for the winner only, combinationally from the valids and the pointer. On the handshake it latches op/a/b into alu_op/alu_data1/alu_data2 and records the winner in `owner`. Next state is ISSUE. With no valid request it stays in IDLE.
- ISSUE: alu_* are held stable. The ALU samples them at the end of this cycle. Next state is CAPTURE.
- CAPTURE: alu_result reflects the issued operation. The block latches it into the result register and sets zero = (alu_result == 0) across the full WIDTH. It sets resp<owner>_valid. Next state is RESP.
- RESP: respOwner_valid, result and zero are held until respOwner_ready is high. On that handshake valid clears next cycle and the FSM goes to IDLE. No new request is accepted in the handshake cycle.
- Arbitration is round-robin with a 1-bit pointer `last`:
  - Both valid: grant the requester that is not `last`.
  - One valid: grant it regardless of pointer.
  - `last` updates to the winner on each accept.
- The non-owner's respN_valid is always 0. respN_result/respN_zero are driven only from the shared result register. Consumers qualify them with valid.
- alu_* hold their last issued values outside ISSUE. The ALU keeps re-evaluating them, which is harmless because results are captured only in CAPTURE.
- The block performs no arithmetic itself; opcode semantics belong to the ALU. Undefined opcodes pass through unchanged.

## Timing
- Reset values:
  - FSM = IDLE, `last` = 1 (so req0 wins the first tie).
  - reqN_ready = 0 while rst is high.
  - respN_valid = 0.
  - alu_op = 0, alu_data1 = alu_data2 = 0.
  - Result register = 0, zero = 0.
- Accept-to-response latency: request accepted in cycle T (IDLE) → ISSUE T+1 → CAPTURE T+2 → respN_valid high in cycle T+3.
- Minimum occupancy is 4 cycles per operation when resp_ready is already high, so the next accept is no earlier than T+4.
- reqN_ready is high only in IDLE. Requesters hold valid and operands until ready is seen.
- resp_ready low stalls indefinitely in RESP. No other requester is served during the stall.
- A request arriving while busy waits. The round-robin pointer guarantees it is served before a repeat of the other requester when both keep valid asserted.
- rst asserted in any state, including mid-ISSUE/CAPTURE/RESP: on the next edge all state returns to reset values. The in-flight operation is dropped and no response is produced. A requester must re-present the request after reset.
- Simultaneous events: a resp handshake and new request valids in the same cycle produce an accept on the following IDLE cycle, not the same cycle.

## Test plan
- Single op: req0 add a=5, b=7 accepted at T → resp0_valid at T+3, result=12, zero=0. resp1_valid stays 0 throughout.
- Zero flag: req1 sub a=9, b=9 → resp1 result=0, zero=1. Then req1 set-less-than a=3, b=8 → result=1, zero=0.
- Tie and round-robin: req0 and req1 both valid continuously, each issuing an or. Grants go in order 0,1,0,1 across four operations, and each response returns to the correct port with correct data.
- Backpressure: resp0_ready held low for 10 cycles. resp0_valid and result stay stable, and req1 (valid throughout) gets no ready. Raise resp0_ready → req1 is accepted on the first IDLE cycle after the handshake.
- Reset mid-operation: assert rst in CAPTURE → next cycle all outputs are at reset values, no respN_valid ever pulses for the dropped operation, and a fresh request then completes normally with req0 winning the first tie.
- Shift/not pass-through: shl a=1, b=4 → 16; not a=0 → 0xFFFFFFFF, zero=0. alu_op/alu_data* are observed stable through the ISSUE cycle.
